// File: rtl/dr_mem_port_if.sv
// Bus/memory-side signal bundle for the dr_mem_port data register.
// Latency: none; pure wiring between the control unit, the memory and the register.
// Backpressure: the master stalls while busy is high and resumes on mem_done.
interface dr_mem_port_if #(
  parameter int BUS_W  = 16,
  parameter int DATA_W = 8
);
  // Control-unit side requests and bus data
  logic [BUS_W-1:0]  in_bus;
  logic              Read;
  logic              Write;
  logic              Mem_Read;
  logic              Mem_Write;
  // Memory side
  logic [DATA_W-1:0] memory_out;
  logic [DATA_W-1:0] memory_in;
  logic              mem_we;
  // Results and status
  logic [BUS_W-1:0]  out_bus;
  logic              busy;
  logic              mem_done;
  logic              collision;

  // Control unit plus memory model drive the requests and memory read data
  modport master (
    output in_bus, Read, Write, Mem_Read, Mem_Write, memory_out,
    input  memory_in, mem_we, out_bus, busy, mem_done, collision
  );

  // The data register itself
  modport slave (
    input  in_bus, Read, Write, Mem_Read, Mem_Write, memory_out,
    output memory_in, mem_we, out_bus, busy, mem_done, collision
  );
endinterface

// File: rtl/dr_mem_port.sv
// Data register between the internal bus and data memory, with multi-cycle memory sequencing.
// Latency: out_bus 1 cycle after Read; memory read/write completes MEM_LAT edges after acceptance.
// Backpressure: busy is high while a sequence runs; requests arriving then are dropped and flagged on collision.
module dr_mem_port #(
  parameter int BUS_W    = 16,
  parameter int DATA_W   = 8,
  parameter int MEM_LAT  = 2,
  parameter int SIGN_EXT = 0
) (
  input  logic          clk,
  input  logic          rst,
  dr_mem_port_if.slave  io_dr
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WR_WAIT = 2'd2;

  // The counter starts at MEM_LAT-1 so the finishing edge is exactly MEM_LAT edges after acceptance
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [BUS_W-1:0]  r_out_bus;
  logic              r_mem_we;
  logic              r_busy;
  logic              r_done;
  logic              r_coll;

  logic [BUS_W-1:0]  w_ext;
  logic              w_any_req;

  // Register value widened to the bus, zero- or sign-filled
  generate
    if (BUS_W > DATA_W) begin : g_ext
      logic w_fill;
      assign w_fill = (SIGN_EXT != 0) & r_data[DATA_W-1];
      assign w_ext  = {{(BUS_W - DATA_W){w_fill}}, r_data};
    end else begin : g_noext
      assign w_ext = r_data;
    end
  endgenerate

  // Any request that would be dropped while a sequence is running
  assign w_any_req = io_dr.Write | io_dr.Mem_Read | io_dr.Mem_Write;

  // Sequencer, register and registered bus output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_data    <= '0;
      r_out_bus <= '0;
      r_mem_we  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_coll    <= 1'b0;
    end else begin
      // Read is honoured in every state and returns the pre-edge register
      r_out_bus <= io_dr.Read ? w_ext : '0;
      r_done    <= 1'b0;
      r_coll    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (io_dr.Mem_Read) begin
            // Read wins; a concurrent bus load or memory write is lost
            r_state <= S_RD_WAIT;
            r_cnt   <= LAT_M1;
            r_busy  <= 1'b1;
            r_coll  <= io_dr.Write | io_dr.Mem_Write;
          end else if (io_dr.Mem_Write) begin
            // A simultaneous Write loads first so the fresh value is what gets stored
            r_state  <= S_WR_WAIT;
            r_cnt    <= LAT_M1;
            r_busy   <= 1'b1;
            r_mem_we <= 1'b1;
            if (io_dr.Write) begin
              r_data <= io_dr.in_bus[DATA_W-1:0];
            end
          end else if (io_dr.Write) begin
            r_data <= io_dr.in_bus[DATA_W-1:0];
          end
        end

        S_RD_WAIT: begin
          r_coll <= w_any_req;
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_data  <= io_dr.memory_out;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_WR_WAIT: begin
          // Register (and so memory_in) is frozen while the write strobe is up
          r_coll <= w_any_req;
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_mem_we <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= 4'd0;
          r_mem_we <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign io_dr.memory_in = r_data;
  assign io_dr.out_bus   = r_out_bus;
  assign io_dr.mem_we    = r_mem_we;
  assign io_dr.busy      = r_busy;
  assign io_dr.mem_done  = r_done;
  assign io_dr.collision = r_coll;

endmodule

// File: doc/dr_mem_port.md
Name: dr_mem_port

Overview:
- Parametrised data register: the next generation of the processor's bus/memory data register.
- Sits between the 16-bit internal bus and data memory, as today's data register does.
- Adds over the current block: configurable data/bus width, sign/zero extension, multi-cycle memory read/write sequencing, a busy/done handshake and a collision flag.
- The control unit stalls on busy and advances on mem_done.

Parameters:
- BUS_W, 16: internal bus width.
- DATA_W, 8: register and memory word width; DATA_W <= BUS_W.
- MEM_LAT, 2: memory access latency in cycles; legal range 1..15.
- SIGN_EXT, 0: 0 = zero-extend onto out_bus, 1 = sign-extend.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_bus  in  BUS_W  data from internal bus.
- Read  in  1  drive register onto out_bus.
- Write  in  1  load register from in_bus[DATA_W-1:0].
- Mem_Read  in  1  start memory read into register.
- Mem_Write  in  1  start memory write from register.
- memory_out  in  DATA_W  data from memory.
- memory_in  out  DATA_W  data to memory; mirrors register.
- mem_we  out  1  memory write strobe.
- out_bus  out  BUS_W  registered bus output.
- busy  out  1  memory sequence in progress.
- mem_done  out  1  one-cycle pulse at end of a memory sequence.
- collision  out  1  one-cycle pulse: a request was dropped.

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - register, memory_in, out_bus: 0.
  - mem_we, busy, mem_done, collision: 0.
  - State IDLE, cnt 0.
  - rst has priority over every input.
  - Asserting rst mid-sequence aborts it: mem_we and busy are 0 after that edge and no mem_done is issued.
- out_bus:
  - Registered every edge with 1-cycle latency, honoured in all states.
  - Read=1: out_bus <= extended pre-edge register. Extension is zero-fill, or replication of register[DATA_W-1] when SIGN_EXT=1.
  - Read=0: out_bus <= 0.
- memory_in: always updated on the same edge as register, with the same value.
- States: IDLE, RD_WAIT, WR_WAIT. cnt is 4-bit.
- IDLE, request priority Mem_Read > Mem_Write > Write:
  - Mem_Read:
    - -> RD_WAIT, cnt <= MEM_LAT-1, busy <= 1.
    - Any concurrent Write or Mem_Write is dropped and collision pulses.
  - Mem_Write (Mem_Read=0):
    - -> WR_WAIT, cnt <= MEM_LAT-1, busy <= 1, mem_we <= 1.
    - If Write is also set, register/memory_in load in_bus on the same edge and that new value is the one written. This is legal, not a collision.
  - Write alone: register <= in_bus[DATA_W-1:0]; stays IDLE.
- RD_WAIT:
  - cnt != 0: cnt decrements.
  - cnt == 0:
    - register/memory_in <= memory_out.
    - busy <= 0, mem_done <= 1 for one cycle, -> IDLE.
  - memory_out is therefore sampled exactly MEM_LAT edges after the accepting edge.
- WR_WAIT:
  - mem_we stays 1 and memory_in is held constant.
  - cnt == 0: mem_we <= 0, busy <= 0, mem_done <= 1, -> IDLE.
  - mem_we is high for exactly MEM_LAT cycles.
- Busy states (RD_WAIT/WR_WAIT):
  - Write, Mem_Read and Mem_Write are ignored; each such assertion pulses collision.
  - Read still works and returns the current register.
- Back-to-back:
  - A request asserted in the cycle mem_done is high is accepted, since state is IDLE.
  - Minimum spacing between sequences is therefore MEM_LAT+1 cycles.
- Sign extension when SIGN_EXT=1 and BUS_W=16, DATA_W=8: register 0x80 -> out_bus 0xFF80.

Test Plan:
1. rst=1 mid-sequence, with in_bus=0xFFFF and all controls high -> all outputs 0 after the edge; no mem_done pulse.
2. Write with in_bus=0x12A5, then Read next cycle -> out_bus=0x00A5 one cycle after Read. Repeat with SIGN_EXT=1 -> 0xFFA5.
3. MEM_LAT=2: Mem_Read pulse at edge 0, memory_out=0x3C -> busy high 2 cycles; register=0x3C after edge 2; mem_done high for exactly 1 cycle; Read afterwards gives 0x003C.
4. MEM_LAT=3: Write+Mem_Write together with in_bus=0x0055 -> mem_we high exactly 3 cycles with memory_in=0x55 throughout; then mem_done pulse.
5. During RD_WAIT, assert Write with in_bus=0x0099 -> collision pulses; register is unchanged until the read completes with memory_out.
6. Mem_Read+Write in the same IDLE cycle -> read wins; collision=1 for one cycle. Sweep MEM_LAT=1 and 15: mem_done arrives exactly MEM_LAT edges after acceptance.
